// File: rtl/atm_pin_entry.sv
// Keypad front-end for the ATM controller: collects BCD digits while a card
// is inserted, presents the packed PIN word with a one-cycle strobe, waits
// for the accept/reject verdict, aborts idle sessions and locks the card
// after repeated wrong PINs.
//
// Strobe semantics: key_valid, pin_accept and pin_reject are single-cycle
// strobes sampled on the rising clock edge. There is no back-pressure.
// pin_valid and timed_out are single-cycle output strobes. PIN is stable
// from the pin_valid cycle until the next accept, card removal or reset.
module atm_pin_entry #(
  parameter int DIGITS         = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_TRIES      = 3,
  parameter int CNT_W          = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  card_present,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  pin_accept,
  input  logic                  pin_reject,
  output logic [4*DIGITS-1:0]   PIN,
  output logic                  pin_valid,
  output logic [1:0]            digit_count,
  output logic [1:0]            tries_left,
  output logic                  timed_out,
  output logic                  locked,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  localparam int PW = 4 * DIGITS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENTRY  = 2'd1;
  localparam logic [1:0] S_SUBMIT = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  localparam logic [1:0]       DIG_MAX    = 2'(DIGITS);
  localparam logic [1:0]       TRIES_INIT = 2'(MAX_TRIES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  localparam logic [3:0] K_CLEAR  = 4'hA;
  localparam logic [3:0] K_BACK   = 4'hB;
  localparam logic [3:0] K_ENTER  = 4'hE;
  localparam logic [3:0] K_CANCEL = 4'hF;

  logic [1:0]       state;
  logic [PW-1:0]    pin_buf;
  logic [CNT_W-1:0] idle_cnt;

  // Level outputs decoded straight from the state register so they follow
  // an asynchronous reset without waiting for a clock.
  assign busy      = (state == S_SUBMIT);
  assign locked    = (state == S_LOCKED);
  assign fsm_state = state;

  // Session FSM, digit buffer, inactivity counter and output registers.
  // Strobes default low each cycle; card removal takes priority over any
  // key or verdict seen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pin_buf     <= '0;
      idle_cnt    <= '0;
      PIN         <= '0;
      pin_valid   <= 1'b0;
      digit_count <= '0;
      tries_left  <= TRIES_INIT;
      timed_out   <= 1'b0;
    end else begin
      pin_valid <= 1'b0;
      timed_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (card_present) begin
            state       <= S_ENTRY;
            pin_buf     <= '0;
            digit_count <= '0;
            idle_cnt    <= '0;
            tries_left  <= TRIES_INIT;
          end
        end

        S_ENTRY: begin
          if (!card_present) begin
            state       <= S_IDLE;
            pin_buf     <= '0;
            digit_count <= '0;
            idle_cnt    <= '0;
            PIN         <= '0;
          end else if (key_valid) begin
            // Any key, even an unrecognised code, counts as activity.
            idle_cnt <= '0;
            if (key_code <= 4'd9) begin
              if (digit_count < DIG_MAX) begin
                pin_buf     <= {pin_buf[PW-5:0], key_code};
                digit_count <= digit_count + 2'd1;
              end
            end else begin
              case (key_code)
                K_CLEAR: begin
                  pin_buf     <= '0;
                  digit_count <= '0;
                end
                K_BACK: begin
                  if (digit_count != 2'd0) begin
                    pin_buf     <= {4'h0, pin_buf[PW-1:4]};
                    digit_count <= digit_count - 2'd1;
                  end
                end
                K_ENTER: begin
                  if (digit_count == DIG_MAX) begin
                    PIN       <= pin_buf;
                    pin_valid <= 1'b1;
                    state     <= S_SUBMIT;
                  end
                end
                K_CANCEL: begin
                  state       <= S_IDLE;
                  pin_buf     <= '0;
                  digit_count <= '0;
                end
                default: ;
              endcase
            end
          end else if (idle_cnt == CNT_LAST) begin
            timed_out   <= 1'b1;
            state       <= S_IDLE;
            pin_buf     <= '0;
            digit_count <= '0;
            idle_cnt    <= '0;
          end else if (idle_cnt != CNT_SAT) begin
            idle_cnt <= idle_cnt + CNT_ONE;
          end
        end

        S_SUBMIT: begin
          idle_cnt <= '0;
          if (!card_present) begin
            state       <= S_IDLE;
            pin_buf     <= '0;
            digit_count <= '0;
            PIN         <= '0;
          end else if (pin_reject) begin
            // Reject wins when both verdict strobes arrive together.
            tries_left  <= tries_left - 2'd1;
            pin_buf     <= '0;
            digit_count <= '0;
            state       <= (tries_left == 2'd1) ? S_LOCKED : S_ENTRY;
          end else if (pin_accept) begin
            state       <= S_IDLE;
            tries_left  <= TRIES_INIT;
            pin_buf     <= '0;
            digit_count <= '0;
            PIN         <= '0;
          end
        end

        S_LOCKED: begin
          if (!card_present) begin
            state      <= S_IDLE;
            tries_left <= TRIES_INIT;
            PIN        <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
